// File: rtl/datamem_pkg.sv
// rtl/datamem_pkg.sv - shared types and defaults for the data memory arbiter
//
// Purpose: default widths, FSM state type, memory request bundle and the
// port identifier used to remember which port was granted most recently.
// Optional feature macro used by this slice: DATAMEM_CLEAR_EN (zero-fill sweep).
package datamem_pkg;

    localparam int AW_DEF = 8;
    localparam int DW_DEF = 8;

    typedef enum logic {ST_CLEAR, ST_RUN} arb_state_t;

    typedef struct packed {
        logic              we;
        logic [AW_DEF-1:0] addr;
        logic [DW_DEF-1:0] wdata;
    } mem_req_t;

    typedef enum logic {PORT_A, PORT_B} port_t;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-requester round-robin grant core
//
// Purpose: grants at most one of two requesters per cycle; on a tie the
// requester not granted most recently wins.
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous active-low reset
//   req     in   [1:0] request (bit 0 = port A, bit 1 = port B)
//   enable  in   grants allowed this cycle
//   gnt     out  [1:0] one-hot (or zero) grant, combinational from req
import datamem_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    port_t last_grant;

    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == PORT_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Only a cycle that actually grants moves the fairness pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= PORT_B;
        end else if (gnt[0]) begin
            last_grant <= PORT_A;
        end else if (gnt[1]) begin
            last_grant <= PORT_B;
        end
    end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-port round-robin sequencer in front of DataMem
//
// Purpose: shares the single-port data memory between the core (port A) and
// the host/DMA loader (port B), registers read data per port, and with
// DATAMEM_CLEAR_EN defined zero-fills the memory after every reset.
// Ports:
//   Clk, Reset                  clock, asynchronous active-low reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_gnt)
//   a_gnt, a_rdata, a_rvalid    port A grant, registered read data, 1-cycle valid
//   b_*                         same for port B
//   mem_we/mem_addr/mem_wdata   DataMem control, driven by the granted port
//   mem_rdata                   DataMem combinational read data
//   busy                        zero-fill sweep in progress
import datamem_pkg::*;

module datamem_arbiter #(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          a_req,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic          a_gnt,
    output logic [DW-1:0] a_rdata,
    output logic          a_rvalid,
    input  logic          b_req,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [DW-1:0] b_wdata,
    output logic          b_gnt,
    output logic [DW-1:0] b_rdata,
    output logic          b_rvalid,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    arb_state_t state, state_nxt;
    logic [1:0] gnt;
    logic       run_en;

    // Gating with Reset keeps grants (and so mem_we) low the instant reset
    // asserts, so a write in flight at that edge never commits.
    assign run_en = (state == ST_RUN) && Reset;

    rr_arb2 u_rr_arb2 (
        .clk    (Clk),
        .rst_n  (Reset),
        .req    ({b_req, a_req}),
        .enable (run_en),
        .gnt    (gnt)
    );

    assign a_gnt = gnt[0];
    assign b_gnt = gnt[1];

`ifdef DATAMEM_CLEAR_EN
    localparam logic [AW-1:0] CLR_LAST = '1;
    logic [AW-1:0] clr_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_CLEAR) begin
                clr_cnt <= clr_cnt + 1'b1;
            end
        end
    end
`else
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (state)
            ST_CLEAR: begin
`ifdef DATAMEM_CLEAR_EN
                busy     = 1'b1;
                mem_we   = Reset;
                mem_addr = clr_cnt;
                if (clr_cnt == CLR_LAST) begin
                    state_nxt = ST_RUN;
                end
`else
                state_nxt = ST_RUN;
`endif
            end
            default: begin
                if (gnt[0]) begin
                    mem_we    = a_we;
                    mem_addr  = a_addr;
                    mem_wdata = a_wdata;
                end else if (gnt[1]) begin
                    mem_we    = b_we;
                    mem_addr  = b_addr;
                    mem_wdata = b_wdata;
                end
            end
        endcase
    end

    // Read data is captured from the combinational DataMem output at the
    // edge ending the grant cycle and held until that port reads again.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= gnt[0] & ~a_we;
            b_rvalid <= gnt[1] & ~b_we;
            if (gnt[0] & ~a_we) begin
                a_rdata <= mem_rdata;
            end
            if (gnt[1] & ~b_we) begin
                b_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - scoreboard bench for datamem_arbiter with a DataMem model
module tb_datamem_arbiter;

    localparam int DEPTH = 256;
`ifdef DATAMEM_CLEAR_EN
    localparam logic EXP_BUSY = 1'b1;
`else
    localparam logic EXP_BUSY = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;
    logic       a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [7:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid, mem_we, busy;
    logic [7:0] a_rdata, b_rdata, mem_addr, mem_wdata, mem_rdata;

    logic [7:0] mem [DEPTH];

    datamem_arbiter #(.AW(8), .DW(8)) dut (
        .Clk(Clk), .Reset(Reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    typedef struct packed {
        logic       req;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wd;
    } rq_t;

    typedef struct packed {
        logic       ag, bg, arv, brv;
        logic [7:0] ard, brd;
        logic       we;
        logic [7:0] addr, wd;
    } exp_t;

    exp_t exp_q[$];
    rq_t  qa[$], qb[$];

    int   errors = 0;
    int   checks = 0;

    logic [7:0] ref_mem [DEPTH];
    logic       ref_last_b = 1'b1;
    logic [7:0] held_a = '0, held_b = '0;
    logic       nxrv_a = 1'b0, nxrv_b = 1'b0;
    logic       prev_ga = 1'b0, prev_gb = 1'b0;
    rq_t        cur_a = '0, cur_b = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic rq_t mk(input logic req, input logic we, input logic [7:0] addr, input logic [7:0] wd);
        rq_t r;
        r.req = req; r.we = we; r.addr = addr; r.wd = wd;
        return r;
    endfunction

    // Reference: each cycle at most one port wins; on a tie the port that did
    // not win last time wins. Writes update the array; reads return its value
    // one cycle later and that value stays until the port's next read.
    task automatic run_cycle();
        exp_t e;
        logic ga, gb;
        if (!cur_a.req || prev_ga) cur_a = (qa.size() > 0) ? qa.pop_front() : '0;
        if (!cur_b.req || prev_gb) cur_b = (qb.size() > 0) ? qb.pop_front() : '0;
        a_req = cur_a.req; a_we = cur_a.we; a_addr = cur_a.addr; a_wdata = cur_a.wd;
        b_req = cur_b.req; b_we = cur_b.we; b_addr = cur_b.addr; b_wdata = cur_b.wd;
        ga = 1'b0; gb = 1'b0;
        if (cur_a.req && cur_b.req) begin
            if (ref_last_b) ga = 1'b1; else gb = 1'b1;
        end else if (cur_a.req) begin
            ga = 1'b1;
        end else if (cur_b.req) begin
            gb = 1'b1;
        end
        e.ag = ga; e.bg = gb;
        e.arv = nxrv_a; e.brv = nxrv_b; e.ard = held_a; e.brd = held_b;
        e.we = 1'b0; e.addr = '0; e.wd = '0;
        nxrv_a = 1'b0; nxrv_b = 1'b0;
        if (ga) begin
            ref_last_b = 1'b0;
            e.we = cur_a.we; e.addr = cur_a.addr; e.wd = cur_a.wd;
            if (cur_a.we) ref_mem[cur_a.addr] = cur_a.wd;
            else begin nxrv_a = 1'b1; held_a = ref_mem[cur_a.addr]; end
        end
        if (gb) begin
            ref_last_b = 1'b1;
            e.we = cur_b.we; e.addr = cur_b.addr; e.wd = cur_b.wd;
            if (cur_b.we) ref_mem[cur_b.addr] = cur_b.wd;
            else begin nxrv_b = 1'b1; held_b = ref_mem[cur_b.addr]; end
        end
        exp_q.push_back(e);
        prev_ga = ga; prev_gb = gb;
    endtask

    task automatic run_batch();
        int n = 0;
        while ((qa.size() > 0 || qb.size() > 0 || (cur_a.req && !prev_ga) ||
                (cur_b.req && !prev_gb)) && n < 400) begin
            @(posedge Clk); #1;
            run_cycle();
            n++;
        end
        chk("batch_timeout", (n >= 400) ? 32'd1 : 32'd0, 32'd0);
    endtask

    // Monitor: one expected entry per driven cycle, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_gnt", a_gnt, e.ag);
                chk("b_gnt", b_gnt, e.bg);
                chk("a_rvalid", a_rvalid, e.arv);
                chk("b_rvalid", b_rvalid, e.brv);
                chk("a_rdata", a_rdata, e.ard);
                chk("b_rdata", b_rdata, e.brd);
                chk("mem_we", mem_we, e.we);
                chk("mem_addr", mem_addr, e.addr);
                chk("mem_wdata", mem_wdata, e.wd);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_a_gnt"}, a_gnt, 0);
        chk({tag, "_b_gnt"}, b_gnt, 0);
        chk({tag, "_a_rvalid"}, a_rvalid, 0);
        chk({tag, "_b_rvalid"}, b_rvalid, 0);
        chk({tag, "_a_rdata"}, a_rdata, 0);
        chk({tag, "_b_rdata"}, b_rdata, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_busy"}, busy, EXP_BUSY);
    endtask

    task automatic wait_sweep(input string tag);
        int cnt = 0, bad = 0, n = 0;
        @(negedge Clk);
        while (busy && n < 400) begin
            cnt++;
            if (a_gnt || b_gnt) bad++;
            n++;
            @(negedge Clk);
        end
        chk({tag, "_busy_cycles"}, cnt, EXP_BUSY ? 256 : 0);
        chk({tag, "_no_grant_in_sweep"}, bad, 0);
    endtask

    initial begin
        int   nz;
        logic [7:0] exp7;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = 8'((i % 255) + 1);
            ref_mem[i] = 8'((i % 255) + 1);
        end
        #1 Reset = 1'b0;
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'd0;
        #3;
        check_reset_outputs("reset");

        @(posedge Clk); @(posedge Clk); #1;
        Reset = 1'b1;
        wait_sweep("sweep");
        chk("busy_after_sweep", busy, 0);
        chk("first_grant", a_gnt, 1);
        if (EXP_BUSY) begin
            nz = 0;
            for (int i = 0; i < DEPTH; i++) if (mem[i] != 8'h00) nz++;
            chk("sweep_zero_fill", nz, 0);
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
        end
        @(posedge Clk); #1;
        a_req = 1'b0;
        @(negedge Clk);
        chk("first_rvalid", a_rvalid, 1);
        chk("first_rdata", a_rdata, ref_mem[0]);
        ref_last_b = 1'b0;
        held_a = ref_mem[0];
        @(posedge Clk);

        // Single port write then read-back
        qa.push_back(mk(1, 1, 8'd16, 8'h5A));
        qa.push_back(mk(1, 0, 8'd16, 8'h00));
        run_batch();
        // Lone B write so the following tie starts with A
        qb.push_back(mk(1, 1, 8'd2, 8'h3C));
        run_batch();
        for (int i = 0; i < 6; i++) begin
            qa.push_back(mk(1, 0, 8'd1, 8'h00));
            qb.push_back(mk(1, 0, 8'd2, 8'h00));
        end
        run_batch();
        // Cross-port write/read of the same address in the same cycle
        qa.push_back(mk(1, 1, 8'd244, 8'hFE));
        qb.push_back(mk(1, 0, 8'd244, 8'h00));
        run_batch();
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 20; k++) begin
                qa.push_back(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7)),
                                8'($urandom_range(0, 255))));
                qb.push_back(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 7)),
                                8'($urandom_range(0, 255))));
            end
            run_batch();
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            run_cycle();
        end
        @(negedge Clk); @(negedge Clk);
        chk("scoreboard_drained", exp_q.size(), 0);

        // Reset drops while a granted write waits for its edge
        exp7 = ref_mem[7];
        @(posedge Clk); #1;
        a_req = 1'b1; a_we = 1'b1; a_addr = 8'd7; a_wdata = 8'h33;
        b_req = 1'b0;
        @(negedge Clk);
        chk("midrun_gnt", a_gnt, 1);
        #2 Reset = 1'b0;
        #1;
        check_reset_outputs("midrun");
        @(posedge Clk); #1;
        chk("midrun_no_commit", mem[7], exp7);
        a_req = 1'b0; a_we = 1'b0;
        @(posedge Clk); #1;
        Reset = 1'b1;
        wait_sweep("resweep");
        chk("addr7_after_reset", mem[7], EXP_BUSY ? 8'h00 : exp7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datamem_arbiter.md
# datamem_arbiter

Two-port round-robin arbiter and sequencer in front of the single-port, 8x256 data memory (combinational read, clocked write). It lets the processor core (port A) and a host/DMA loader (port B) share the memory's one address pointer, returns registered read data, and, optionally, clears the memory to zero after reset. It sits between the core's load/store path and the DataMem instance and owns all of DataMem's control inputs.

## Interface
- AW, 8, address width; memory depth 2^AW
- DW, 8, data width
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- a_req  in  1  port A (core) access request
- a_we  in  1  port A write (1) / read (0)
- a_addr  in  AW  port A address
- a_wdata  in  DW  port A write data
- a_gnt  out  1  port A request accepted this cycle
- a_rdata  out  DW  port A read data
- a_rvalid  out  1  port A read data valid
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rdata, b_rvalid: same as port A, for port B (host/DMA)
- mem_we  out  1  to DataMem WriteEn
- mem_addr  out  AW  to DataMem DataAddress
- mem_wdata  out  DW  to DataMem DataIn
- mem_rdata  in  DW  from DataMem DataOut (combinational)
- busy  out  1  clear sweep in progress; both ports locked out

## Operation
- States: ST_CLEAR (sweep) and ST_RUN (arbitrate). Reset enters ST_CLEAR, or ST_RUN when the sweep is compiled out.
- ST_CLEAR: 
  - mem_we=1, mem_addr=clr_cnt, mem_wdata=0. 
  - clr_cnt increments 0..2^AW-1. 
  - On the cycle that writes address 2^AW-1, the next state is ST_RUN. 
  - a_gnt and b_gnt stay 0. busy=1.
- ST_RUN: at most one grant per cycle.
  - If only one port requests, that port is granted.
  - If both request, the port not granted most recently wins.
  - last_grant updates only when a grant is issued.
- Granted port drives the memory that cycle: mem_addr=x_addr; mem_we=x_we; mem_wdata=x_wdata.
- With no grant: mem_we=0, mem_addr=0, mem_wdata=0.
- Granted read: x_rdata<=mem_rdata and x_rvalid<=1 at the next edge. rvalid is a 1-cycle pulse. x_rdata holds its value until the next read on that port.
- Granted write: commits at the edge ending the grant cycle. No rvalid.
- Requester protocol: hold x_req, x_we, x_addr and x_wdata stable until x_gnt=1. Deassert or present the next request after the grant cycle.
- Reset values:
  - a_gnt = b_gnt = 0; a_rvalid = b_rvalid = 0; a_rdata = b_rdata = 0.
  - mem_we = 0 (forced 0 whenever Reset=0); busy = 1 (0 if the sweep is compiled out).
  - clr_cnt = 0; last_grant = B, so A wins the first tie.

## Timing
- Grant is combinational from x_req and state: zero-cycle grant.
- Read latency: data is valid 1 cycle after the grant cycle.
- A port requesting alone is granted every cycle, giving 1 access/cycle.
- Both ports requesting continuously alternate A,B,A,B.
- Read-after-write: a read granted the cycle after a write to the same address returns the new data.
- Reset mid-operation (sweep or run):
  - Outputs go to reset values immediately.
  - A write in flight at that edge is not committed.
  - An in-flight rvalid is dropped.
  - The sweep restarts at address 0.
- Requests during ST_CLEAR are held off, not dropped. The first grant comes in the first ST_RUN cycle.

## Configuration
- DATAMEM_CLEAR_EN defined:
  - ST_CLEAR sweep present.
  - 2^AW cycles (256 by default) after Reset deasserts before the first grant.
  - busy high during the sweep.
- Undefined:
  - No sweep and no clr_cnt.
  - Reset enters ST_RUN directly; busy is tied 0.
  - Memory contents after reset are whatever DataMem holds.

## Structure
- Package datamem_pkg holds:
  - localparams AW_DEF=8, DW_DEF=8.
  - typedef enum logic {ST_CLEAR, ST_RUN} arb_state_t.
  - typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} mem_req_t.
  - typedef enum logic {PORT_A, PORT_B} port_t for last_grant.
- Sub-module rr_arb2 holds the two-requester round-robin core: inputs req[1:0], enable; outputs gnt[1:0]; internal last_grant flop.

## Test plan
- Sweep: preload memory nonzero, then pulse Reset with DATAMEM_CLEAR_EN defined → busy=1 for exactly 256 cycles, no grants, and all 256 locations read back 0.
- Single port: A writes 0x5A to addr 16, then A reads addr 16 the next cycle → a_gnt both cycles, and a_rvalid=1 with a_rdata=0x5A one cycle after the read grant.
- Contention: A and B both read continuously (A addr 1, B addr 2) → grants A,B,A,B starting with A; each rvalid appears one cycle after its own grant with the correct data.
- Write/read cross-port: A writes 0xFE to addr 244 while B requests a read of addr 244 the same cycle → A is granted first, and B's read (granted next cycle) returns 0xFE.
- Reset mid-run: A is granted a write of 0x33 to addr 7 and Reset drops before the edge → no commit (addr 7 reads 0 after the sweep); all outputs are at reset values while Reset=0.
- Macro off: with DATAMEM_CLEAR_EN undefined, Reset deasserts with a_req held → a_gnt=1 in the first cycle; busy stays 0.
